// File: rtl/scarv_soc_dbg_bridge_if.sv
// Byte-stream and memory-bus signals between the debug bridge and its
// environment. The master modport is the bridge side.
interface scarv_soc_dbg_bridge_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
    output tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, mem_gnt, mem_recv, mem_error, mem_rdata,
    input  tx_valid, tx_data, mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack
  );
endinterface

// File: rtl/scarv_soc_dbg_bridge.sv
// Debug host bridge: decodes UART byte commands (WRITE/READ), performs one
// word access on the memory bus and streams a status/data reply back.
module scarv_soc_dbg_bridge #(
  parameter int BYTE_TIMEOUT = 65536,
  parameter int BUS_TIMEOUT  = 1024
) (
  input  logic                         f_clk,
  input  logic                         g_resetn,
  scarv_soc_dbg_bridge_if.master       bus,
  output logic                         busy,
  output logic                         overrun
);
  localparam int BTO_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] OP_WR     = 8'h01;
  localparam logic [7:0] OP_RD     = 8'h02;
  localparam logic [7:0] RSP_BERR  = 8'hEE;
  localparam logic [7:0] RSP_ALIGN = 8'hEC;
  localparam logic [7:0] RSP_TOUT  = 8'hED;
  localparam logic [7:0] RSP_BADOP = 8'hEF;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CHECK, S_BUS_REQ, S_BUS_RSP, S_TX
  } state_t;

  state_t            r_state;
  logic              r_wr;
  logic [1:0]        r_idx;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  // Reply bytes, least significant byte is the one currently on tx_data.
  logic [39:0]       r_txbuf;
  logic [2:0]        r_txcnt;
  logic [BTO_W-1:0]  r_bto;
  logic [BUS_W-1:0]  r_bus_to;
  logic              r_tx_valid;
  logic              r_mem_req;
  logic              r_mem_ack;
  logic [3:0]        r_strb;
  logic              r_overrun;

  logic w_byte_tout;
  logic w_bus_tout;
  logic w_tx_fire;
  logic w_rx_drop;

  assign w_byte_tout = (r_bto == BTO_W'(BYTE_TIMEOUT - 1));
  assign w_bus_tout  = (r_bus_to == BUS_W'(BUS_TIMEOUT - 1));
  assign w_tx_fire   = r_tx_valid && bus.tx_ready;
  // Bytes arriving while a command is being executed or answered are lost.
  assign w_rx_drop   = bus.rx_valid && (r_state == S_CHECK || r_state == S_BUS_REQ ||
                                        r_state == S_BUS_RSP || r_state == S_TX);

  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_txbuf[7:0];
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_wen   = r_wr;
  assign bus.mem_strb  = r_strb;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_ack   = r_mem_ack;
  assign busy          = (r_state != S_IDLE);
  assign overrun       = r_overrun;

  // Command decode, bus access and reply sequencing.
  always_ff @(posedge f_clk) begin
    if (!g_resetn) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_txbuf    <= '0;
      r_txcnt    <= '0;
      r_bto      <= '0;
      r_bus_to   <= '0;
      r_tx_valid <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_ack  <= 1'b0;
      r_strb     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_strb <= 4'hF;
      if (w_rx_drop) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            r_wr  <= (bus.rx_data == OP_WR);
            r_idx <= '0;
            r_bto <= '0;
            if (bus.rx_data == OP_WR || bus.rx_data == OP_RD) begin
              r_state <= S_ADDR;
            end else begin
              r_txbuf    <= {32'h0, RSP_BADOP};
              r_txcnt    <= 3'd1;
              r_tx_valid <= 1'b1;
              r_state    <= S_TX;
            end
          end
        end

        S_ADDR, S_DATA: begin
          if (bus.rx_valid) begin
            r_bto <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_state == S_ADDR) r_addr[{r_idx, 3'b000} +: 8]  <= bus.rx_data;
            else                   r_wdata[{r_idx, 3'b000} +: 8] <= bus.rx_data;
            if (r_idx == 2'd3)
              r_state <= (r_state == S_ADDR && r_wr) ? S_DATA : S_CHECK;
          end else if (w_byte_tout) begin
            r_state <= S_IDLE;
          end else begin
            r_bto <= r_bto + 1'b1;
          end
        end

        S_CHECK: begin
          if (r_addr[1:0] != 2'b00) begin
            r_txbuf    <= {32'h0, RSP_ALIGN};
            r_txcnt    <= 3'd1;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX;
          end else begin
            r_mem_req <= 1'b1;
            r_bus_to  <= '0;
            r_state   <= S_BUS_REQ;
          end
        end

        S_BUS_REQ: begin
          if (bus.mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_ack <= 1'b1;
            r_bus_to  <= '0;
            r_state   <= S_BUS_RSP;
          end else if (w_bus_tout) begin
            r_mem_req  <= 1'b0;
            r_txbuf    <= {32'h0, RSP_TOUT};
            r_txcnt    <= 3'd1;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX;
          end else begin
            r_bus_to <= r_bus_to + 1'b1;
          end
        end

        S_BUS_RSP: begin
          if (bus.mem_recv) begin
            r_mem_ack  <= 1'b0;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX;
            if (bus.mem_error) begin
              r_txbuf <= {32'h0, RSP_BERR};
              r_txcnt <= 3'd1;
            end else if (r_wr) begin
              r_txbuf <= {32'h0, OP_WR};
              r_txcnt <= 3'd1;
            end else begin
              r_txbuf <= {bus.mem_rdata, OP_RD};
              r_txcnt <= 3'd5;
            end
          end else if (w_bus_tout) begin
            r_mem_ack  <= 1'b0;
            r_txbuf    <= {32'h0, RSP_TOUT};
            r_txcnt    <= 3'd1;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX;
          end else begin
            r_bus_to <= r_bus_to + 1'b1;
          end
        end

        S_TX: begin
          if (w_tx_fire) begin
            r_txbuf <= {8'h00, r_txbuf[39:8]};
            r_txcnt <= r_txcnt - 3'd1;
            if (r_txcnt == 3'd1) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scarv_soc_dbg_bridge.sv
// Scoreboard bench for the debug bridge: expected reply bytes are queued when
// a command is issued and compared as the bridge transmits them.
module tb_scarv_soc_dbg_bridge;
  logic f_clk = 1'b0;
  logic g_resetn;
  logic busy, overrun;

  scarv_soc_dbg_bridge_if bif ();

  scarv_soc_dbg_bridge dut (
    .f_clk    (f_clk),
    .g_resetn (g_resetn),
    .bus      (bif),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 f_clk = ~f_clk;

  int checks = 0;
  int errs   = 0;
  int req_cycles = 0;
  int tx_mode = 0;               // 0: always ready, 1: toggle, 2: never ready
  logic [7:0] exp_q[$];
  logic       prev_wait = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transmitter side: ready pattern chosen by the sequence
  always @(posedge f_clk) begin
    #1;
    case (tx_mode)
      0:       bif.tx_ready = 1'b1;
      1:       bif.tx_ready = ~bif.tx_ready;
      default: bif.tx_ready = 1'b0;
    endcase
  end

  // Reply monitor, sampled mid-cycle
  always @(negedge f_clk) begin
    if (!g_resetn) begin
      prev_wait = 1'b0;
    end else begin
      if (bif.mem_req) req_cycles++;
      if (prev_wait) chk("tx_hold", {bif.tx_valid, bif.tx_data}, {1'b1, prev_data});
      if (bif.tx_valid && bif.tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", {1'b1, bif.tx_data}, 0);
        else chk("tx_byte", bif.tx_data, exp_q.pop_front());
      end
      prev_wait = bif.tx_valid && !bif.tx_ready;
      prev_data = bif.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    @(posedge f_clk); #1;
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_rd(input logic [31:0] a);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic push_rd_ok(input logic [31:0] d);
    exp_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  // Memory responder for one access: grant after gd cycles, respond rd cycles later
  task automatic bus_txn(input int gd, input int rd, input logic err, input logic [31:0] rdata,
                         input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic inject);
    int n = 0;
    @(negedge f_clk);
    while (!bif.mem_req && n < 200) begin @(negedge f_clk); n++; end
    chk("req_seen", bif.mem_req, 1);
    chk("req_wen",  bif.mem_wen, wen);
    chk("req_strb", bif.mem_strb, 4'hF);
    chk("req_addr", bif.mem_addr, addr);
    if (wen) chk("req_wdata", bif.mem_wdata, wdata);
    repeat (gd) begin
      @(negedge f_clk);
      chk("req_stable", {bif.mem_req, bif.mem_wen, bif.mem_addr}, {1'b1, wen, addr});
    end
    @(posedge f_clk); #1 bif.mem_gnt = 1'b1;
    @(posedge f_clk); #1 bif.mem_gnt = 1'b0;
    #1;
    chk("req_drop", bif.mem_req, 0);
    chk("rsp_ack",  bif.mem_ack, 1);
    if (inject) begin bif.rx_valid = 1'b1; bif.rx_data = 8'h55; end
    repeat (rd) begin @(posedge f_clk); #1 bif.rx_valid = 1'b0; end
    bif.mem_recv = 1'b1; bif.mem_error = err; bif.mem_rdata = rdata;
    @(posedge f_clk); #1;
    bif.mem_recv = 1'b0; bif.mem_error = 1'b0; bif.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge f_clk);
    while ((busy || exp_q.size() != 0) && n < bound) begin @(negedge f_clk); n++; end
    chk("idle_queue", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_txv", bif.tx_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    g_resetn = 1'b0;
    bif.rx_valid = 0; bif.rx_data = 0; bif.tx_ready = 0;
    bif.mem_gnt = 0; bif.mem_recv = 0; bif.mem_error = 0; bif.mem_rdata = 0;
    repeat (3) @(posedge f_clk); #1;
    chk("rst_outs", {bif.tx_valid, bif.mem_req, bif.mem_ack, bif.mem_wen, busy, overrun}, 0);
    chk("rst_bus", {bif.mem_addr, bif.mem_wdata, bif.mem_strb, bif.tx_data}, 0);
    g_resetn = 1'b1;
    @(posedge f_clk); #1;

    // WRITE, grant after 2 cycles
    exp_q.push_back(8'h01);
    send_wr(32'h0001_0004, 32'hDEAD_BEEF);
    bus_txn(2, 1, 1'b0, 32'h0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0);
    wait_idle(100);

    // READ, immediate grant and response
    push_rd_ok(32'h1234_5678);
    send_rd(32'h0002_0000);
    bus_txn(0, 0, 1'b0, 32'h1234_5678, 1'b0, 32'h0002_0000, 32'h0, 1'b0);
    wait_idle(100);

    // Same READ with a stalling transmitter
    tx_mode = 1;
    push_rd_ok(32'h1234_5678);
    send_rd(32'h0002_0000);
    bus_txn(1, 2, 1'b0, 32'h1234_5678, 1'b0, 32'h0002_0000, 32'h0, 1'b0);
    wait_idle(100);
    tx_mode = 0;

    // Misaligned READ never touches the bus
    rc = req_cycles;
    exp_q.push_back(8'hEC);
    send_rd(32'h0001_0002);
    wait_idle(100);
    chk("misalign_noreq", req_cycles - rc, 0);

    // Unknown opcode, then a normal READ
    exp_q.push_back(8'hEF);
    send_byte(8'h7F);
    wait_idle(100);
    push_rd_ok(32'hCAFE_F00D);
    send_rd(32'h0000_0010);
    bus_txn(0, 1, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    wait_idle(100);

    // Bus error on WRITE
    exp_q.push_back(8'hEE);
    send_wr(32'h0000_0100, 32'h0BAD_F00D);
    bus_txn(1, 2, 1'b1, 32'h0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 1'b0);
    wait_idle(100);

    // Grant never comes: timeout after 1024 request cycles, late strobes ignored
    rc = req_cycles;
    exp_q.push_back(8'hED);
    send_rd(32'h0000_0200);
    wait_idle(3000);
    chk("tout_req_cycles", req_cycles - rc, 1024);
    bif.mem_gnt = 1'b1; bif.mem_recv = 1'b1;
    @(posedge f_clk); #1;
    bif.mem_gnt = 1'b0; bif.mem_recv = 1'b0;
    @(negedge f_clk);
    chk("late_ignored", {busy, bif.mem_req, bif.mem_ack, bif.tx_valid}, 0);

    // Partial command abandoned after the byte timeout
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    repeat (65530) @(posedge f_clk); #1;
    chk("bto_still_busy", busy, 1);
    repeat (10) @(posedge f_clk); #1;
    chk("bto_idle", {busy, bif.tx_valid}, 0);
    push_rd_ok(32'hA5A5_0F0F);
    send_rd(32'h0000_0040);
    bus_txn(0, 0, 1'b0, 32'hA5A5_0F0F, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    wait_idle(100);

    // Byte dropped during BUS_RSP sets overrun, reply unaffected
    chk("ovr_before", overrun, 0);
    push_rd_ok(32'h0102_0304);
    send_rd(32'h0000_0080);
    bus_txn(0, 3, 1'b0, 32'h0102_0304, 1'b0, 32'h0000_0080, 32'h0, 1'b1);
    wait_idle(100);
    chk("ovr_set", overrun, 1);

    // Reset while a reply is being offered
    tx_mode = 2;
    send_rd(32'h0000_00C0);
    bus_txn(0, 0, 1'b0, 32'h7777_8888, 1'b0, 32'h0000_00C0, 32'h0, 1'b0);
    @(negedge f_clk);
    chk("pre_rst_txv", {bif.tx_valid, bif.tx_data, busy}, {1'b1, 8'h02, 1'b1});
    @(posedge f_clk); #1 g_resetn = 1'b0;
    @(posedge f_clk); #1;
    chk("rst_tx", {bif.tx_valid, busy, overrun, bif.mem_req, bif.mem_ack}, 0);
    g_resetn = 1'b1;
    tx_mode = 0;
    exp_q.delete();
    repeat (3) @(posedge f_clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
